minute_set_counter: RTL and testbench

- Source of the 6-bit minute values (MIN, AMIN) that the minute display controller consumes.
- Keeps the running clock minute, advanced by a one-minute tick pulse.
- Keeps the alarm minute.
- Lets the user edit either value with debounced UP/DOWN buttons, selected by ALARM.
- Emits CARRY to the hour counter and MATCH to the alarm logic.

---
 rtl/clock_pkg.sv | 17 +
 rtl/btn_debounce.sv | 77 +++++++
 rtl/minute_set_counter.sv | 79 +++++++
 tb/tb_minute_set_counter.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/clock_pkg.sv
// Shared time-keeping types and modulo helpers for the minute, second and hour counters.
package clock_pkg;

    typedef logic [5:0] minute_t;

    localparam minute_t MINUTE_MAX = 6'd59;

    function automatic minute_t wrap_inc(input minute_t v, input minute_t max = MINUTE_MAX);
        return (v >= max) ? minute_t'(0) : minute_t'(v + 6'd1);
    endfunction

    // Out-of-range values fold to max so a corrupted register heals on the next step.
    function automatic minute_t wrap_dec(input minute_t v, input minute_t max = MINUTE_MAX);
        return (v == '0 || v > max) ? max : minute_t'(v - 6'd1);
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Button conditioner: 2-FF synchronizer, debounce counter and press pulse.
// AUTO_REPEAT_EN adds hold-to-repeat press events.
module btn_debounce #(
    parameter int DEB_CYCLES = 4
`ifdef AUTO_REPEAT_EN
    ,
    parameter int REP_DELAY  = 8,
    parameter int REP_RATE   = 4
`endif
) (
    input  logic CLK,
    input  logic RST,
    input  logic raw,
    output logic press
);

    localparam int CW = $clog2(DEB_CYCLES + 1);

    logic [1:0]    sync;
    logic [CW-1:0] cnt;
    logic          level;
    logic          level_q;
    logic          rise;

    // Level flips only after DEB_CYCLES consecutive disagreeing samples.
    always_ff @(posedge CLK) begin
        if (RST) begin
            sync    <= '0;
            cnt     <= '0;
            level   <= 1'b0;
            level_q <= 1'b0;
        end else begin
            sync    <= {sync[0], raw};
            level_q <= level;
            if (sync[1] != level) begin
                if (cnt == CW'(DEB_CYCLES - 1)) begin
                    level <= sync[1];
                    cnt   <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else begin
                cnt <= '0;
            end
        end
    end

    assign rise = level & ~level_q;

`ifdef AUTO_REPEAT_EN
    localparam int RMAX = (REP_DELAY > REP_RATE) ? REP_DELAY : REP_RATE;
    localparam int RW   = $clog2(RMAX + 1);

    logic [RW-1:0] rep;
    logic          rep_fire;

    // Countdown to the next repeat; reloaded by the initial press, then by each repeat.
    assign rep_fire = level & level_q & (rep == '0);

    always_ff @(posedge CLK) begin
        if (RST) begin
            rep <= '0;
        end else if (rise) begin
            rep <= RW'(REP_DELAY - 1);
        end else if (rep_fire) begin
            rep <= RW'(REP_RATE - 1);
        end else if (level && rep != '0) begin
            rep <= rep - 1'b1;
        end
    end

    assign press = rise | rep_fire;
`else
    assign press = rise;
`endif

endmodule

// File: rtl/minute_set_counter.sv
// Clock and alarm minute registers with tick advance, button editing, CARRY and MATCH.
// Optional hold-to-repeat on the buttons via AUTO_REPEAT_EN.
module minute_set_counter
    import clock_pkg::*;
#(
    parameter int DEB_CYCLES = 4,
    parameter int REP_DELAY  = 8,
    parameter int REP_RATE   = 4
) (
    input  logic    CLK,
    input  logic    RST,
    input  logic    MIN_TICK,
    input  logic    ALARM,
    input  logic    BTN_UP,
    input  logic    BTN_DN,
    output minute_t MIN,
    output minute_t AMIN,
    output logic    CARRY,
    output logic    MATCH
);

    if (DEB_CYCLES < 1 || REP_DELAY < 1 || REP_RATE < 1) begin : g_param_chk
        $error("minute_set_counter: DEB_CYCLES, REP_DELAY and REP_RATE must be >= 1");
    end

    logic [1:0] raw;
    logic [1:0] ev;     // [0] up, [1] down
    logic       inc, dec;
    minute_t    min_t, min_n, amin_n;
    logic       carry_n, match_n;

    assign raw = {BTN_DN, BTN_UP};

    btn_debounce #(
        .DEB_CYCLES(DEB_CYCLES)
`ifdef AUTO_REPEAT_EN
        ,
        .REP_DELAY (REP_DELAY),
        .REP_RATE  (REP_RATE)
`endif
    ) u_btn [1:0] (
        .CLK  (CLK),
        .RST  (RST),
        .raw  (raw),
        .press(ev)
    );

    // Simultaneous up and down events cancel.
    assign inc = ev[0] & ~ev[1];
    assign dec = ev[1] & ~ev[0];

    // Tick is applied before a coincident MIN edit.
    always_comb begin
        min_t   = MIN_TICK ? wrap_inc(MIN) : MIN;
        min_n   = min_t;
        amin_n  = AMIN;
        if (!ALARM && inc)      min_n  = wrap_inc(min_t);
        else if (!ALARM && dec) min_n  = wrap_dec(min_t);
        if (ALARM && inc)       amin_n = wrap_inc(AMIN);
        else if (ALARM && dec)  amin_n = wrap_dec(AMIN);
        carry_n = MIN_TICK && (MIN == MINUTE_MAX);
        match_n = MIN_TICK && (min_n == amin_n);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            MIN   <= '0;
            AMIN  <= '0;
            CARRY <= 1'b0;
            MATCH <= 1'b0;
        end else begin
            MIN   <= min_n;
            AMIN  <= amin_n;
            CARRY <= carry_n;
            MATCH <= match_n;
        end
    end

endmodule

// File: tb/tb_minute_set_counter.sv
// Directed scoreboard bench for minute_set_counter (DEB_CYCLES=4, REP_DELAY=8, REP_RATE=4).
module tb_minute_set_counter;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       MIN_TICK = 1'b0;
    logic       ALARM = 1'b0;
    logic       BTN_UP = 1'b0;
    logic       BTN_DN = 1'b0;
    logic [5:0] MIN, AMIN;
    logic       CARRY, MATCH;

    minute_set_counter #(.DEB_CYCLES(4), .REP_DELAY(8), .REP_RATE(4)) dut (
        .CLK(CLK), .RST(RST), .MIN_TICK(MIN_TICK), .ALARM(ALARM),
        .BTN_UP(BTN_UP), .BTN_DN(BTN_DN),
        .MIN(MIN), .AMIN(AMIN), .CARRY(CARRY), .MATCH(MATCH)
    );

    always #5 CLK = ~CLK;

    typedef struct { string tag; int val; } exp_t;
    exp_t sb[$];
    int checks = 0;
    int errors = 0;
    int carry_cnt = 0;
    int match_cnt = 0;
    int mmin = 0;
    int mamin = 0;

    always @(negedge CLK) begin
        if (!RST) begin
            carry_cnt += int'(CARRY);
            match_cnt += int'(MATCH);
        end
    end

    task automatic push(input string tag, input int v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        sb.push_back(e);
    endtask

    task automatic pop_chk(input int obs);
        exp_t e;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $error("FAIL scoreboard_empty got %0d", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.val) else begin
                errors++;
                $error("FAIL %s got %0d exp %0d", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge CLK);
    endtask

    // Clean press: 8 synchronized high samples, then let the release settle.
    task automatic press(input logic up, input logic dn);
        BTN_UP = up;
        BTN_DN = dn;
        cyc(8);
        BTN_UP = 1'b0;
        BTN_DN = 1'b0;
        cyc(12);
    endtask

    task automatic tick();
        MIN_TICK = 1'b1;
        cyc(1);
        MIN_TICK = 1'b0;
    endtask

    function automatic int inc60(input int v); return (v + 1) % 60; endfunction
    function automatic int dec60(input int v); return (v + 59) % 60; endfunction

    initial begin
        int c0;
        int m0;
        // Reset state
        cyc(3);
        push("rst_min", 0);   pop_chk(int'(MIN));
        push("rst_amin", 0);  pop_chk(int'(AMIN));
        push("rst_carry", 0); pop_chk(int'(CARRY));
        push("rst_match", 0); pop_chk(int'(MATCH));
        RST = 1'b0;
        cyc(2);

        // 61 ticks: MIN 1..59,0,1; CARRY and MATCH (AMIN=0) only on the 59->0 tick
        for (int i = 1; i <= 61; i++) begin
            mmin = inc60(mmin);
            push($sformatf("tick_min_%0d", i), mmin);
            push($sformatf("tick_carry_%0d", i), (i == 60) ? 1 : 0);
            push($sformatf("tick_match_%0d", i), (mmin == mamin) ? 1 : 0);
            tick();
            pop_chk(int'(MIN));
            pop_chk(int'(CARRY));
            pop_chk(int'(MATCH));
            cyc(2);
        end
        push("tick_carry_total", 1); pop_chk(carry_cnt);

        // Bounced UP press edits AMIN exactly at stable start + 7 edges
        ALARM = 1'b1;
        BTN_UP = 1'b1; cyc(1);
        BTN_UP = 1'b0; cyc(1);
        BTN_UP = 1'b1;
        cyc(6);
        push("deb_before", 0); pop_chk(int'(AMIN));
        cyc(1);
        mamin = inc60(mamin);
        push("deb_at", mamin); pop_chk(int'(AMIN));
        cyc(1);
        BTN_UP = 1'b0;
        cyc(12);
        push("deb_once", mamin); pop_chk(int'(AMIN));
        push("deb_min_same", mmin); pop_chk(int'(MIN));

        // MIN edits via DN: 1->0->59, no CARRY; both buttons cancel
        ALARM = 1'b0;
        c0 = carry_cnt;
        press(1'b0, 1'b1); mmin = dec60(mmin);
        push("dn_to0", mmin); pop_chk(int'(MIN));
        press(1'b0, 1'b1); mmin = dec60(mmin);
        push("dn_wrap", mmin); pop_chk(int'(MIN));
        push("dn_no_carry", c0); pop_chk(carry_cnt);
        press(1'b1, 1'b1);
        push("both_cancel", mmin); pop_chk(int'(MIN));

        // MIN=58, AMIN=59: tick raises MATCH
        press(1'b0, 1'b1); mmin = dec60(mmin);
        ALARM = 1'b1;
        press(1'b0, 1'b1); mamin = dec60(mamin);
        press(1'b0, 1'b1); mamin = dec60(mamin);
        push("set_amin59", mamin); pop_chk(int'(AMIN));
        ALARM = 1'b0;
        tick(); mmin = inc60(mmin);
        push("m_tick_min", mmin); pop_chk(int'(MIN));
        push("m_tick_match", 1);  pop_chk(int'(MATCH));
        cyc(2);
        m0 = match_cnt;
        ALARM = 1'b1;
        press(1'b1, 1'b0); mamin = inc60(mamin);
        ALARM = 1'b0;
        press(1'b1, 1'b0); mmin = inc60(mmin);
        press(1'b0, 1'b1); mmin = dec60(mmin);
        push("edit_no_match", m0); pop_chk(match_cnt);
        push("edit_min59", mmin); pop_chk(int'(MIN));
        tick(); mmin = inc60(mmin);
        push("cm_min", mmin); pop_chk(int'(MIN));
        push("cm_carry", 1);  pop_chk(int'(CARRY));
        push("cm_match", 1);  pop_chk(int'(MATCH));
        cyc(2);

        // MIN=59, tick coincident with UP press event -> MIN=1 with CARRY
        press(1'b0, 1'b1); mmin = dec60(mmin);
        BTN_UP = 1'b1;
        cyc(6);
        MIN_TICK = 1'b1;
        cyc(1);
        MIN_TICK = 1'b0;
        mmin = inc60(inc60(mmin));
        push("co_min", mmin); pop_chk(int'(MIN));
        push("co_carry", 1);  pop_chk(int'(CARRY));
        push("co_match", 0);  pop_chk(int'(MATCH));
        cyc(1);
        BTN_UP = 1'b0;
        cyc(12);

        // Long hold on UP with ALARM=1: repeats only with AUTO_REPEAT_EN
        ALARM = 1'b1;
        BTN_UP = 1'b1;
        cyc(31);
        BTN_UP = 1'b0;
        cyc(14);
`ifdef AUTO_REPEAT_EN
        mamin = (mamin + 7) % 60;
`else
        mamin = inc60(mamin);
`endif
        push("hold_amin", mamin); pop_chk(int'(AMIN));
        push("hold_min", mmin);   pop_chk(int'(MIN));

        // Reset mid-press: cleared, then exactly one event after full debounce
        ALARM = 1'b0;
        BTN_UP = 1'b1;
        cyc(3);
        RST = 1'b1;
        cyc(2);
        push("rstp_min", 0);  pop_chk(int'(MIN));
        push("rstp_amin", 0); pop_chk(int'(AMIN));
        RST = 1'b0;
        cyc(8);
        BTN_UP = 1'b0;
        cyc(12);
        push("rstp_after", 1); pop_chk(int'(MIN));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule
